snake_frame_sequencer: RTL and testbench
========================================

# snake_frame_sequencer

Frame-level controller between the VGA timing driver and the snake game logic. Watches the driver's `row` output to find the start of vertical blanking. Every `speed+1` frames it issues a request/done update handshake to the game logic, which must finish inside the blanking window. Also gates the driver's `enable` and flags updates that overrun.

## Interface
Parameters:
- `VIS_ROWS`, default 600: row value the driver holds for the whole vertical blanking interval.
- `TIMEOUT`, default 60000: maximum clk cycles allowed in UPDATE.
- `STEP_W`, default 16: width of the step counter.

Ports:
- `clk`  in  1  pixel clock, same clock as the VGA driver.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `row`  in  10  current row from the VGA driver. Equals 0..599 in the visible area and is held at `VIS_ROWS` during vertical blanking.
- `run`  in  1  game running. When 0 the display is blanked and all sequencing stops.
- `pause`  in  1  freezes the frame divider and suppresses update requests; the display stays on.
- `speed`  in  4  frames per game step, minus 1.
- `upd_done`  in  1  one-cycle (or longer) acknowledge from the game logic.
- `enable`  out  1  enable to the VGA driver.
- `upd_req`  out  1  level request to the game logic, held until done or abort.
- `frame_tick`  out  1  one-cycle pulse at each vertical-blanking start.
- `step_cnt`  out  STEP_W  number of completed updates.
- `overrun`  out  1  sticky error flag.
- `state`  out  2  debug: 0=IDLE, 1=RENDER, 2=UPDATE.

## Operation
- Blanking-start detect:
  - `row_d` is `row` registered, reset value 0.
  - `vb_start = (row == VIS_ROWS) && (row_d != VIS_ROWS)`.
- Frame divider `fcnt` (4 bits):
  - Increments on each `vb_start` while in RENDER with `pause=0`.
  - When `vb_start` occurs with `fcnt >= speed`: `fcnt` clears and an update is launched.
  - Using `>=` means a `speed` decrease mid-count launches an update on the next blanking start.
- States:
  - IDLE: `enable=0`, `upd_req=0`. Goes to RENDER when `run=1`; the same edge clears `fcnt` and `step_cnt`.
  - RENDER: `enable=1`. Goes to UPDATE on a launch condition (`vb_start`, `pause=0`, `fcnt>=speed`).
  - UPDATE: `enable=1`, `upd_req=1`; timeout counter `tcnt` runs from 0.
    - `upd_done=1`: go to RENDER, `step_cnt` increments (wraps modulo 2^STEP_W).
    - Otherwise, `tcnt == TIMEOUT-1` or `row != VIS_ROWS` (blanking ended): set `overrun=1`, go to RENDER, `step_cnt` does not increment.
    - `upd_done` together with a timeout or blanking end: done wins, no overrun.
  - `run=0` in any state: go to IDLE on the next edge; `upd_req` drops and `fcnt` clears. `overrun` keeps its value.
  - `upd_done` seen outside UPDATE is ignored.
- `overrun` clears only on reset.
- Speed change: `speed` is sampled only at `vb_start`.

## Timing
- Reset values:
  - `enable=0`, `upd_req=0`, `frame_tick=0`, `step_cnt=0`, `overrun=0`, `state=IDLE`.
  - Internal: `fcnt=0`, `tcnt=0`, `row_d=0`.
- All outputs are registered. No combinational path from any input to any output.
- `frame_tick` is high for exactly the one cycle after the edge at which `vb_start` was true. Its timing is independent of state, `run` and `pause`.
- Launch latency: `upd_req` rises on the edge after the edge at which `vb_start` is true, i.e. the same cycle as `frame_tick`.
- Completion: `upd_done` high at edge N gives `upd_req=0`, the incremented `step_cnt`, and `state=RENDER` after edge N.
- `enable` rises one cycle after `run` is first sampled high, and falls one cycle after `run` is sampled low.
- Reset asserted mid-UPDATE: all outputs return to reset values immediately (asynchronously).

## Test plan
- Reset, then `run=1`, `speed=0`; drive `row` 0..599 then 600 held for 100 cycles.
  - Required: `frame_tick` is a single pulse, `upd_req` rises on the same cycle.
  - `upd_done` pulsed 10 cycles later gives `step_cnt=1`, `overrun=0`.
- `speed=2`, 7 frames, done acknowledged 5 cycles after each request.
  - Required: requests on frames 3 and 6 only, `step_cnt=2`, seven `frame_tick` pulses.
- `upd_done` never asserted, `TIMEOUT=50`, blanking 100 cycles long.
  - Required: `upd_req` drops after exactly 50 cycles, `overrun=1`, `step_cnt` unchanged; `overrun` stays set through later frames.
- Blanking only 20 cycles long, no done.
  - Required: abort on the first cycle with `row=0`, `overrun=1`.
  - Then `upd_done` asserted on the same edge as the timeout: required `step_cnt` increments and no new overrun.
- `pause=1` for 3 frames, then `pause=0`, with `speed=1`.
  - Required: no requests while paused, `fcnt` frozen, `frame_tick` still pulses every frame, `enable=1` throughout.
- `run` dropped mid-UPDATE.
  - Required: next cycle `state=IDLE`, `enable=0`, `upd_req=0`.
  - Raising `run` again clears `step_cnt` to 0.
  - Then `rst_n` asserted mid-UPDATE: all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/snake_frame_sequencer.sv
// ---------------------------------------------------------------------------
// snake_frame_sequencer
//
// Frame-level controller between the VGA timing driver and the snake game
// logic. It watches the driver's row counter to find the start of vertical
// blanking, divides frames down to game steps, and runs a request/done
// handshake with the game logic that has to finish inside the blanking window.
// It also gates the driver's enable and flags updates that overrun.
//
// Parameters:
//   VIS_ROWS   row value the driver holds for the whole vertical blanking
//   TIMEOUT    maximum clk cycles an update may take
//   STEP_W     width of the completed-update counter
//
// Ports:
//   clk         pixel clock shared with the VGA driver
//   rst_n       asynchronous active-low reset
//   row         current row from the VGA driver (VIS_ROWS during blanking)
//   run         game running; 0 blanks the display and stops sequencing
//   pause       freezes the frame divider and suppresses update requests
//   speed       frames per game step minus one
//   upd_done    acknowledge from the game logic
//   enable      enable to the VGA driver
//   upd_req     level request to the game logic
//   frame_tick  one-cycle pulse after each vertical-blanking start
//   step_cnt    number of completed updates
//   overrun     sticky error flag for aborted updates
//   state       debug state: 0=IDLE, 1=RENDER, 2=UPDATE
// ---------------------------------------------------------------------------
module snake_frame_sequencer #(
   parameter int VIS_ROWS = 600,
   parameter int TIMEOUT  = 60000,
   parameter int STEP_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        row,
   input  logic              run,
   input  logic              pause,
   input  logic [3:0]        speed,
   input  logic              upd_done,
   output logic              enable,
   output logic              upd_req,
   output logic              frame_tick,
   output logic [STEP_W-1:0] step_cnt,
   output logic              overrun,
   output logic [1:0]        state
);

   localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [9:0]        BLANK_ROW = 10'(VIS_ROWS);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RENDER = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [9:0]          rowPrev_q;
   logic [3:0]          fcnt_q, fcnt_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
   logic                overrun_q, overrun_d;
   logic                frameTick_q;
   logic                enable_q, enable_d;
   logic                updReq_q, updReq_d;
   logic                vbStart;

   // Blanking starts on the first cycle the driver shows the blanking row
   // after having shown anything else. Comparing against the registered row
   // makes this a single-cycle event no matter how long blanking lasts.
   always_comb begin
      vbStart = (row == BLANK_ROW) && (rowPrev_q != BLANK_ROW);
   end

   // Next-state logic. Dropping run overrides everything and parks the
   // machine in IDLE. In UPDATE a done acknowledge is checked before the
   // timeout and blanking-end aborts, so an acknowledge arriving on the same
   // edge as an abort still counts as a completed step. The divider uses >=
   // so that lowering speed mid-count launches on the next blanking start
   // instead of waiting for a 4-bit wrap. enable and upd_req are derived from
   // the next state so they come straight out of flops.
   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      tcnt_d    = tcnt_q;
      stepCnt_d = stepCnt_q;
      overrun_d = overrun_q;

      if (!run) begin
         state_d = ST_IDLE;
         fcnt_d  = '0;
         tcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_RENDER;
               fcnt_d    = '0;
               stepCnt_d = '0;
            end
            ST_RENDER: begin
               if (vbStart && !pause) begin
                  if (fcnt_q >= speed) begin
                     fcnt_d  = '0;
                     tcnt_d  = '0;
                     state_d = ST_UPDATE;
                  end else begin
                     fcnt_d = fcnt_q + 4'd1;
                  end
               end
            end
            ST_UPDATE: begin
               tcnt_d = tcnt_q + TCNT_W'(1);
               if (upd_done) begin
                  state_d   = ST_RENDER;
                  stepCnt_d = stepCnt_q + STEP_W'(1);
                  tcnt_d    = '0;
               end else if ((tcnt_q == TCNT_LAST) || (row != BLANK_ROW)) begin
                  state_d   = ST_RENDER;
                  overrun_d = 1'b1;
                  tcnt_d    = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      enable_d = (state_d != ST_IDLE);
      updReq_d = (state_d == ST_UPDATE);
   end

   // State and output registers. Everything clears asynchronously so a reset
   // in the middle of an update takes the request away at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rowPrev_q   <= '0;
         fcnt_q      <= '0;
         tcnt_q      <= '0;
         stepCnt_q   <= '0;
         overrun_q   <= 1'b0;
         frameTick_q <= 1'b0;
         enable_q    <= 1'b0;
         updReq_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rowPrev_q   <= row;
         fcnt_q      <= fcnt_d;
         tcnt_q      <= tcnt_d;
         stepCnt_q   <= stepCnt_d;
         overrun_q   <= overrun_d;
         frameTick_q <= vbStart;
         enable_q    <= enable_d;
         updReq_q    <= updReq_d;
      end
   end

   assign enable     = enable_q;
   assign upd_req    = updReq_q;
   assign frame_tick = frameTick_q;
   assign step_cnt   = stepCnt_q;
   assign overrun    = overrun_q;
   assign state      = state_q;

endmodule

// File: tb/tb_snake_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_snake_frame_sequencer
//
// Self-checking bench for snake_frame_sequencer. Frames are driven as a full
// visible sweep followed by a blanking hold of selectable length and one
// cycle of row 0. A frame-level reference model predicts, for each frame,
// whether an update is launched, how many cycles the request stays up, and
// the resulting step count and overrun flag.
// ---------------------------------------------------------------------------
module tb_snake_frame_sequencer;

   localparam int VisRows   = 600;
   localparam int TbTimeout = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  row = 10'd0;
   logic        run = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  speed = 4'd0;
   logic        upd_done = 1'b0;
   logic        enable;
   logic        upd_req;
   logic        frame_tick;
   logic [15:0] step_cnt;
   logic        overrun;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   int doneDelay = -1;
   int reqRun = 0;
   int frTicks, frReqRises, frReqCycles, frEnableLow;
   bit frReqWithTick;

   int mFcnt = 0;
   int mStep = 0;
   bit mOvr = 1'b0;

   snake_frame_sequencer #(
      .VIS_ROWS(VisRows),
      .TIMEOUT (TbTimeout),
      .STEP_W  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .run       (run),
      .pause     (pause),
      .speed     (speed),
      .upd_done  (upd_done),
      .enable    (enable),
      .upd_req   (upd_req),
      .frame_tick(frame_tick),
      .step_cnt  (step_cnt),
      .overrun   (overrun),
      .state     (state)
   );

   always #5 clk = ~clk;

   // One clock: advance past the edge, drop any done pulse, record what the
   // outputs did, and raise done once the request has been up doneDelay cycles.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      upd_done = 1'b0;
      if (frame_tick) frTicks++;
      if (upd_req) begin
         if (reqRun == 0) begin
            frReqRises++;
            frReqWithTick = frame_tick;
         end
         reqRun++;
         frReqCycles++;
      end else begin
         reqRun = 0;
      end
      if (!enable) frEnableLow++;
      if (upd_req && doneDelay > 0 && reqRun == doneDelay) upd_done = 1'b1;
   endtask

   task automatic run_frame(input int blankLen);
      frTicks = 0; frReqRises = 0; frReqCycles = 0; frEnableLow = 0;
      frReqWithTick = 1'b0;
      for (int r = 1; r < VisRows; r++) begin
         row = 10'(r);
         applyStimulus();
      end
      for (int b = 0; b < blankLen; b++) begin
         row = 10'(VisRows);
         applyStimulus();
      end
      row = 10'd0;
      applyStimulus();
   endtask

   // Frame-level model: an unpaused blanking start launches once speed+1
   // unpaused frames have gone by; the update then ends at whichever comes
   // first of the acknowledge, the timeout, or the end of blanking, with the
   // acknowledge winning a tie.
   task automatic model_frame(input bit p, input int spd, input int blankLen,
                              input int d, output bit launch, output int reqc);
      int limit;
      launch = 1'b0;
      reqc = 0;
      if (!p) begin
         if (mFcnt >= spd) begin
            launch = 1'b1;
            mFcnt = 0;
         end else begin
            mFcnt++;
         end
      end
      if (launch) begin
         limit = (blankLen < TbTimeout) ? blankLen : TbTimeout;
         if (d > 0 && d <= limit) begin
            reqc = d;
            mStep = (mStep + 1) % 65536;
         end else begin
            reqc = limit;
            mOvr = 1'b1;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; run = 1'b0; pause = 1'b0; upd_done = 1'b0; row = 10'd0;
      doneDelay = -1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mFcnt = 0; mStep = 0; mOvr = 1'b0;
   endtask

   task automatic start_run();
      run = 1'b1;
      row = 10'd0;
      applyStimulus();
      mFcnt = 0; mStep = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if ({enable, upd_req, frame_tick, overrun, state, step_cnt} !== 22'd0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {enable, upd_req, frame_tick, overrun, state, step_cnt}); end
      run = 1'b1;
      #1;
      checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL enable_before_edge: got %b expected 0", enable); end
      start_run();
      checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL enable_rise: got %b expected 1", enable); end
      checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL state_render: got %0d expected 1", state); end
   endtask

   task automatic test_single_update();
      bit launch; int reqc;
      speed = 4'd0; doneDelay = 10;
      run_frame(100);
      model_frame(1'b0, 0, 100, 10, launch, reqc);
      checks++; if (frTicks !== 1) begin errors++; $display("[TB] FAIL single_ticks: got %0d expected 1", frTicks); end
      checks++; if (frReqRises !== 1) begin errors++; $display("[TB] FAIL single_req_rises: got %0d expected 1", frReqRises); end
      checks++; if (frReqWithTick !== 1'b1) begin errors++; $display("[TB] FAIL single_req_with_tick: got %b expected 1", frReqWithTick); end
      checks++; if (frReqCycles !== reqc) begin errors++; $display("[TB] FAIL single_req_len: got %0d expected %0d", frReqCycles, reqc); end
      checks++; if (step_cnt !== 16'(mStep)) begin errors++; $display("[TB] FAIL single_step: got %0d expected %0d", step_cnt, mStep); end
      checks++; if (overrun !== mOvr) begin errors++; $display("[TB] FAIL single_overrun: got %b expected %b", overrun, mOvr); end
   endtask

   task automatic test_divider();
      bit launch; int reqc; int ticks; logic [6:0] mask; logic [6:0] expMask;
      speed = 4'd2; doneDelay = 5; ticks = 0; mask = '0; expMask = '0;
      for (int f = 0; f < 7; f++) begin
         run_frame(100);
         model_frame(1'b0, 2, 100, 5, launch, reqc);
         ticks += frTicks;
         mask[f] = (frReqRises > 0);
         expMask[f] = launch;
      end
      checks++; if (mask !== 7'b0100100) begin errors++; $display("[TB] FAIL divider_frames: got %b expected 0100100", mask); end
      checks++; if (mask !== expMask) begin errors++; $display("[TB] FAIL divider_model: got %b expected %b", mask, expMask); end
      checks++; if (ticks !== 7) begin errors++; $display("[TB] FAIL divider_ticks: got %0d expected 7", ticks); end
      checks++; if (step_cnt !== 16'(mStep)) begin errors++; $display("[TB] FAIL divider_step: got %0d expected %0d", step_cnt, mStep); end
   endtask

   task automatic test_timeout();
      bit launch; int reqc; int stepBefore;
      speed = 4'd0; doneDelay = -1; stepBefore = mStep;
      run_frame(100);
      model_frame(1'b0, 0, 100, -1, launch, reqc);
      checks++; if (frReqCycles !== TbTimeout) begin errors++; $display("[TB] FAIL timeout_len: got %0d expected %0d", frReqCycles, TbTimeout); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL timeout_overrun: got %b expected 1", overrun); end
      checks++; if (step_cnt !== 16'(stepBefore)) begin errors++; $display("[TB] FAIL timeout_step: got %0d expected %0d", step_cnt, stepBefore); end
      doneDelay = 5;
      run_frame(100);
      model_frame(1'b0, 0, 100, 5, launch, reqc);
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); end
      checks++; if (step_cnt !== 16'(mStep)) begin errors++; $display("[TB] FAIL timeout_next_step: got %0d expected %0d", step_cnt, mStep); end
   endtask

   task automatic test_short_blank();
      bit launch; int reqc;
      doneDelay = -1;
      run_frame(20);
      model_frame(1'b0, 0, 20, -1, launch, reqc);
      checks++; if (frReqCycles !== 20) begin errors++; $display("[TB] FAIL blank_abort_len: got %0d expected 20", frReqCycles); end
      checks++; if ({upd_req, state} !== 3'b001) begin errors++; $display("[TB] FAIL blank_abort_state: got %b expected 001", {upd_req, state}); end
      checks++; if (overrun !== mOvr) begin errors++; $display("[TB] FAIL blank_abort_overrun: got %b expected %b", overrun, mOvr); end
   endtask

   task automatic test_done_wins();
      bit launch; int reqc;
      apply_reset();
      start_run();
      speed = 4'd0; doneDelay = TbTimeout;
      run_frame(100);
      model_frame(1'b0, 0, 100, TbTimeout, launch, reqc);
      checks++; if (frReqCycles !== reqc) begin errors++; $display("[TB] FAIL done_at_timeout_len: got %0d expected %0d", frReqCycles, reqc); end
      checks++; if ({overrun, step_cnt} !== {mOvr, 16'(mStep)}) begin errors++; $display("[TB] FAIL done_at_timeout: got ovr=%b step=%0d expected ovr=%b step=%0d", overrun, step_cnt, mOvr, mStep); end
      doneDelay = 20;
      run_frame(20);
      model_frame(1'b0, 0, 20, 20, launch, reqc);
      checks++; if ({overrun, step_cnt} !== {mOvr, 16'(mStep)}) begin errors++; $display("[TB] FAIL done_at_blank_end: got ovr=%b step=%0d expected ovr=%b step=%0d", overrun, step_cnt, mOvr, mStep); end
   endtask

   task automatic test_pause();
      bit launch; int reqc; int ticks; int rises; int enLow;
      speed = 4'd1; doneDelay = 5; pause = 1'b1; ticks = 0; rises = 0; enLow = 0;
      for (int f = 0; f < 3; f++) begin
         run_frame(100);
         model_frame(1'b1, 1, 100, 5, launch, reqc);
         ticks += frTicks; rises += frReqRises; enLow += frEnableLow;
      end
      checks++; if (ticks !== 3) begin errors++; $display("[TB] FAIL pause_ticks: got %0d expected 3", ticks); end
      checks++; if (rises !== 0) begin errors++; $display("[TB] FAIL pause_requests: got %0d expected 0", rises); end
      checks++; if (enLow !== 0) begin errors++; $display("[TB] FAIL pause_enable_low_cycles: got %0d expected 0", enLow); end
      pause = 1'b0;
      run_frame(100);
      model_frame(1'b0, 1, 100, 5, launch, reqc);
      checks++; if ((frReqRises > 0) !== launch) begin errors++; $display("[TB] FAIL unpause_frame1: got %0d expected %0d", frReqRises, launch); end
      run_frame(100);
      model_frame(1'b0, 1, 100, 5, launch, reqc);
      checks++; if ((frReqRises > 0) !== launch) begin errors++; $display("[TB] FAIL unpause_frame2: got %0d expected %0d", frReqRises, launch); end
      checks++; if (step_cnt !== 16'(mStep)) begin errors++; $display("[TB] FAIL pause_step: got %0d expected %0d", step_cnt, mStep); end
   endtask

   task automatic test_run_drop();
      int waited;
      speed = 4'd0; doneDelay = -1;
      for (int r = 1; r < VisRows; r++) begin
         row = 10'(r);
         applyStimulus();
      end
      row = 10'(VisRows);
      waited = 0;
      while (upd_req !== 1'b1 && waited < 20) begin
         applyStimulus();
         waited++;
      end
      checks++; if (upd_req !== 1'b1) begin errors++; $display("[TB] FAIL run_drop_launch: got %b expected 1", upd_req); end
      repeat (3) applyStimulus();
      run = 1'b0;
      applyStimulus();
      checks++; if ({state, enable, upd_req} !== 4'b0000) begin errors++; $display("[TB] FAIL run_drop_idle: got %b expected 0000", {state, enable, upd_req}); end
      checks++; if ({overrun, step_cnt} !== {mOvr, 16'(mStep)}) begin errors++; $display("[TB] FAIL run_drop_hold: got ovr=%b step=%0d expected ovr=%b step=%0d", overrun, step_cnt, mOvr, mStep); end
      start_run();
      checks++; if ({state, step_cnt} !== {2'd1, 16'd0}) begin errors++; $display("[TB] FAIL run_restart: got state=%0d step=%0d expected state=1 step=0", state, step_cnt); end
   endtask

   task automatic test_async_reset();
      row = 10'd0;
      applyStimulus();
      row = 10'(VisRows);
      applyStimulus();
      checks++; if ({upd_req, frame_tick} !== 2'b11) begin errors++; $display("[TB] FAIL async_setup: got %b expected 11", {upd_req, frame_tick}); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({enable, upd_req, frame_tick, overrun, state, step_cnt} !== 22'd0) begin errors++; $display("[TB] FAIL async_reset: got %h expected 0", {enable, upd_req, frame_tick, overrun, state, step_cnt}); end
      apply_reset();
   endtask

   task automatic test_random();
      bit launch; int reqc; bit p; int spd; int blankLen; int d;
      start_run();
      for (int f = 0; f < 12; f++) begin
         p = (($urandom % 4) == 0);
         spd = int'($urandom % 4);
         case ($urandom % 3)
            0: blankLen = 20;
            1: blankLen = 100;
            default: blankLen = int'($urandom_range(21, 120));
         endcase
         case ($urandom % 4)
            0: d = -1;
            1: d = blankLen;
            2: d = int'($urandom_range(1, 60));
            default: d = TbTimeout;
         endcase
         pause = p; speed = 4'(spd); doneDelay = d;
         run_frame(blankLen);
         model_frame(p, spd, blankLen, d, launch, reqc);
         checks++; if (frTicks !== 1) begin errors++; $display("[TB] FAIL rand_ticks f%0d: got %0d expected 1", f, frTicks); end
         checks++; if ((frReqRises > 0) !== launch) begin errors++; $display("[TB] FAIL rand_launch f%0d: got %0d expected %0d", f, frReqRises, launch); end
         checks++; if (frReqCycles !== reqc) begin errors++; $display("[TB] FAIL rand_req_len f%0d: got %0d expected %0d", f, frReqCycles, reqc); end
         checks++; if ({overrun, step_cnt} !== {mOvr, 16'(mStep)}) begin errors++; $display("[TB] FAIL rand_result f%0d: got ovr=%b step=%0d expected ovr=%b step=%0d", f, overrun, step_cnt, mOvr, mStep); end
         checks++; if (frEnableLow !== 0) begin errors++; $display("[TB] FAIL rand_enable f%0d: got %0d low cycles expected 0", f, frEnableLow); end
      end
      pause = 1'b0;
   endtask

   initial begin
      $display("[TB] starting snake_frame_sequencer bench");
      test_reset();
      test_single_update();
      test_divider();
      test_timeout();
      test_short_blank();
      test_done_wins();
      test_pause();
      test_run_drop();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guards against a stuck run; the bench never needs anywhere near this long.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
